// File: rtl/serial_arith_pkg.sv
// Shared types for the digit-serial arithmetic blocks.
// State encoding and add/subtract mode codes.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple add/subtract slice.
// Chains full-adder or full-subtractor cells LSB to MSB.
module addsub_digit
  import serial_arith_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cb_in,
  input  logic             mode,
  output logic [DIGIT-1:0] r,
  output logic             cb_out
);

  logic c;

  // Ripple carry/borrow through the slice bit by bit
  always_comb begin
    c = cb_in;
    r = '0;
    for (int i = 0; i < DIGIT; i++) begin
      r[i] = a[i] ^ b[i] ^ c;
      if (mode == MODE_SUB)
        c = (!a[i] & b[i]) | (!a[i] & c) | (b[i] & c);
      else
        c = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    cb_out = c;
  end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract unit, LSB digit first.
// Valid/ready on both sides; result held in DONE.
module serial_addsub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             cb_out,
  output logic             ovf
);

  localparam int NSTEP = WIDTH / DIGIT;
  localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  state_e           state_q, state_d;
  logic [SW-1:0]    step_q, step_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cb_q, cb_d;
  logic             mode_q, mode_d;
  logic             am_q, am_d;
  logic             bm_q, bm_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] sl_r;
  logic             sl_cb;
  logic [WIDTH-1:0] res_sh;
  logic             last;
  logic             rmsb;
  logic             ovf_new;

  addsub_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a      (a_q[DIGIT-1:0]),
    .b      (b_q[DIGIT-1:0]),
    .cb_in  (cb_q),
    .mode   (mode_q),
    .r      (sl_r),
    .cb_out (sl_cb)
  );

  if (DIGIT == WIDTH) begin : g_full
    assign res_sh = sl_r;
  end else begin : g_part
    assign res_sh = {sl_r, res_q[WIDTH-1:DIGIT]};
  end

  assign last = (step_q == SW'(NSTEP - 1));
  assign rmsb = sl_r[DIGIT-1];

  // Signed overflow from captured operand MSBs and final result MSB
  always_comb begin
    if (mode_q == MODE_SUB)
      ovf_new = (am_q != bm_q) && (rmsb != am_q);
    else
      ovf_new = (am_q == bm_q) && (rmsb != am_q);
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cb_d    = cb_q;
    mode_d  = mode_q;
    am_d    = am_q;
    bm_d    = bm_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          step_d  = '0;
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          cb_d    = cin;
          am_d    = a[WIDTH-1];
          bm_d    = b[WIDTH-1];
        end
      end
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        res_d = res_sh;
        cb_d  = sl_cb;
        if (last) begin
          state_d = DONE;
          ovf_d   = ovf_new;
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cb_q    <= 1'b0;
      mode_q  <= MODE_ADD;
      am_q    <= 1'b0;
      bm_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cb_q    <= cb_d;
      mode_q  <= mode_d;
      am_q    <= am_d;
      bm_q    <= bm_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign res       = res_q;
  assign cb_out    = cb_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub at DIGIT 1, 4 and 16.
// Random and directed ops vs an arithmetic model.
module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        mode;
  logic        cin;
  logic [15:0] a;
  logic [15:0] b;

  logic [15:0] res_w [3];
  logic        ov_w  [3];
  logic        ir_w  [3];
  logic        cb_w  [3];
  logic        ovf_w [3];

  int nst [3] = '{16, 4, 1};
  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
    serial_addsub #(
      .WIDTH(16),
      .DIGIT(D)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (ir_w[g]),
      .mode      (mode),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (ov_w[g]),
      .out_ready (out_ready),
      .res       (res_w[g]),
      .cb_out    (cb_w[g]),
      .ovf       (ovf_w[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic m, input logic [15:0] x,
                                input logic [15:0] y, input logic ci,
                                output logic [15:0] r, output logic cb,
                                output logic v);
    int sx, sy, s;
    logic [16:0] f;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!m) begin
      f = {1'b0, x} + {1'b0, y} + 17'(ci);
      s = sx + sy + int'(ci);
    end else begin
      f = {1'b0, x} - {1'b0, y} - 17'(ci);
      s = sx - sy - int'(ci);
    end
    r  = f[15:0];
    cb = f[16];
    v  = (s > 32767) || (s < -32768);
  endfunction

  task automatic run_op(input logic m, input logic [15:0] x,
                        input logic [15:0] y, input logic ci);
    logic [15:0] er;
    logic        ec, ev;
    int          lat [3];
    bit          dn [3];
    int          ndone;
    model(m, x, y, ci, er, ec, ev);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rdy%0d", g), 32'(ir_w[g]), 32'd1);
      lat[g] = -1;
      dn[g]  = 1'b0;
    end
    mode = m; a = x; b = y; cin = ci;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    mode = 1'($urandom); cin = 1'($urandom);
    ndone = 0;
    for (int c = 1; c <= 40 && ndone < 3; c++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 3; g++)
        if (!dn[g] && ov_w[g]) begin
          dn[g]  = 1'b1;
          lat[g] = c;
          ndone++;
        end
    end
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("lat%0d", g), 32'(lat[g]), 32'(nst[g]));
      chk($sformatf("res%0d", g), 32'(res_w[g]), 32'(er));
      chk($sformatf("cb%0d", g), 32'(cb_w[g]), 32'(ec));
      chk($sformatf("ovf%0d", g), 32'(ovf_w[g]), 32'(ev));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("idle%0d", g), 32'(ir_w[g]), 32'd1);
      chk($sformatf("ovlo%0d", g), 32'(ov_w[g]), 32'd0);
    end
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] v;
    case ($urandom_range(0, 7))
      0: v = 16'h0000;
      1: v = 16'hFFFF;
      2: v = 16'h8000;
      3: v = 16'h7FFF;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    logic [15:0] r0;
    logic        c0, v0;
    logic [15:0] er;
    logic        ec, ev;
    bit          all;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    mode = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst_rdy%0d", g), 32'(ir_w[g]), 32'd1);
      chk($sformatf("rst_ov%0d", g), 32'(ov_w[g]), 32'd0);
      chk($sformatf("rst_res%0d", g), 32'(res_w[g]), 32'd0);
      chk($sformatf("rst_cb%0d", g), 32'(cb_w[g]), 32'd0);
      chk($sformatf("rst_ovf%0d", g), 32'(ovf_w[g]), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(1'b1, 16'h0005, 16'h0003, 1'b0);
    chk("d1_res", 32'(res_w[1]), 32'h0002);
    chk("d1_cb", 32'(cb_w[1]), 32'd0);
    chk("d1_ovf", 32'(ovf_w[1]), 32'd0);
    run_op(1'b1, 16'h0003, 16'h0005, 1'b0);
    chk("d2_res", 32'(res_w[1]), 32'hFFFE);
    chk("d2_cb", 32'(cb_w[1]), 32'd1);
    chk("d2_ovf", 32'(ovf_w[1]), 32'd0);
    run_op(1'b1, 16'h8000, 16'h0001, 1'b0);
    chk("d3_res", 32'(res_w[1]), 32'h7FFF);
    chk("d3_cb", 32'(cb_w[1]), 32'd0);
    chk("d3_ovf", 32'(ovf_w[1]), 32'd1);
    run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    chk("d4_res", 32'(res_w[1]), 32'h8000);
    chk("d4_cb", 32'(cb_w[1]), 32'd0);
    chk("d4_ovf", 32'(ovf_w[1]), 32'd1);
    run_op(1'b0, 16'hFFFF, 16'h0000, 1'b1);
    chk("d5_res", 32'(res_w[1]), 32'h0000);
    chk("d5_cb", 32'(cb_w[1]), 32'd1);
    chk("d5_ovf", 32'(ovf_w[1]), 32'd0);

    // Back-pressure: hold DONE with out_ready low
    model(1'b0, 16'h9234, 16'hA111, 1'b1, er, ec, ev);
    mode = 1'b0; a = 16'h9234; b = 16'hA111; cin = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    all = 1'b0;
    for (int c = 0; c < 40 && !all; c++) begin
      @(posedge clk); #1;
      all = ov_w[0] && ov_w[1] && ov_w[2];
    end
    chk("bp_reach", 32'(all), 32'd1);
    r0 = res_w[1]; c0 = cb_w[1]; v0 = ovf_w[1];
    chk("bp_res", 32'(r0), 32'(er));
    chk("bp_cb", 32'(c0), 32'(ec));
    chk("bp_ovf", 32'(v0), 32'(ev));
    for (int k = 0; k < 6; k++) begin
      if (k == 2) begin
        in_valid = 1'b1; a = 16'h1111; b = 16'h2222;
        mode = 1'b1; cin = 1'b0;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_hold_res", 32'(res_w[1]), 32'(r0));
      chk("bp_hold_cb", 32'(cb_w[1]), 32'(c0));
      chk("bp_hold_ovf", 32'(ovf_w[1]), 32'(v0));
      chk("bp_rdy", 32'(ir_w[1]), 32'd0);
      chk("bp_ov", 32'(ov_w[1]), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int g = 0; g < 3; g++)
      chk($sformatf("bp_free%0d", g), 32'(ir_w[g]), 32'd1);
    chk("bp_keep", 32'(res_w[1]), 32'(r0));

    // Reset at RUN step 2 aborts the op
    mode = 1'b1; a = 16'hBEEF; b = 16'h1234; cin = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("ab_ov", 32'(ov_w[1]), 32'd0);
    chk("ab_rdy", 32'(ir_w[1]), 32'd1);
    chk("ab_res", 32'(res_w[1]), 32'd0);
    run_op(1'b1, 16'h1234, 16'h0234, 1'b0);
    chk("ab2_res", 32'(res_w[1]), 32'h1000);
    chk("ab2_cb", 32'(cb_w[1]), 32'd0);

    for (int i = 0; i < 1000; i++)
      run_op(1'($urandom), pick(), pick(), 1'($urandom));

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
